// File: rtl/memory_arbiter.sv
// Shares one single-ported RAM between the instruction-fetch and data ports.
// The optional macro ARB_ROUND_ROBIN_EN alternates grants on contention; the default gives data fixed priority.
module memory_arbiter #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, store_q;
  logic        wr_q;
  logic [7:0]  wait_cnt;
  logic        i_req, d_req, grant_i, grant_d;
  logic        in_acc, done, timeout;

  assign i_req = iREN & ~halt;
  assign d_req = dREN | dWEN;

`ifdef ARB_ROUND_ROBIN_EN
  // last_d: 1 when the most recent grant went to the data port.
  logic last_d;
  assign grant_d = d_req & (~i_req | ~last_d);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      last_d <= 1'b0;
    else if (state == IDLE && grant_d)
      last_d <= 1'b1;
    else if (state == IDLE && grant_i)
      last_d <= 1'b0;
  end
`else
  assign grant_d = d_req;
`endif

  assign grant_i = i_req & ~grant_d;
  assign in_acc  = (state != IDLE);
  assign done    = in_acc & ram_ready;
  // Abort on the cycle whose stall would take the count to MAX_WAIT; ready in that cycle still wins.
  assign timeout = in_acc & ~ram_ready & (wait_cnt == 8'(MAX_WAIT - 1));

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    unique case (state)
      IDLE: begin
        if (grant_d)      state_next = DACC;
        else if (grant_i) state_next = IACC;
      end
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = addr_q;
        if (done || timeout) state_next = IDLE;
      end
      DACC: begin
        ramREN   = ~wr_q;
        ramWEN   = wr_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        if (done || timeout) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q   <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
      wait_cnt <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      mem_err  <= 1'b0;
      iload    <= '0;
      dload    <= '0;
    end else begin
      ihit    <= (state == IACC) & (done | timeout);
      dhit    <= (state == DACC) & (done | timeout);
      mem_err <= timeout;

      if (state == IDLE) begin
        if (grant_d) begin
          addr_q   <= daddr;
          store_q  <= dstore;
          wr_q     <= dWEN;
          wait_cnt <= '0;
        end else if (grant_i) begin
          addr_q   <= iaddr;
          store_q  <= '0;
          wr_q     <= 1'b0;
          wait_cnt <= '0;
        end
      end else if (!ram_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (state == IACC && done)         iload <= ramload;
      else if (state == IACC && timeout) iload <= '0;

      if (state == DACC && done && !wr_q) dload <= ramload;
      else if (state == DACC && timeout)  dload <= '0;
    end
  end

endmodule
